// File: rtl/wb_stage_pkg.sv
// Shared constants for the MiniMIPS32 write-back stage: aluop codes, reset level,
// zero words and the load extension helpers.
package wb_stage_pkg;

    localparam int ALUOP_W = 8;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_NOP  = 8'h00,
        ALUOP_MTHI = 8'h0C,
        ALUOP_MTLO = 8'h0D,
        ALUOP_MULT = 8'h14,
        ALUOP_LB   = 8'h90,
        ALUOP_LBU  = 8'h91,
        ALUOP_LH   = 8'h92,
        ALUOP_LHU  = 8'h93,
        ALUOP_LW   = 8'h94
    } aluop_e;

    localparam logic        RST_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [63:0] ZERO_DWORD = 64'h0;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sign_ext);
        return {{24{sign_ext & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sign_ext);
        return {{16{sign_ext & h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_stage_hilo_reg.sv
// Architectural HI/LO register pair: 64-bit write-enabled store with async clear.
module hilo_reg
    import wb_stage_pkg::*;
(
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        we,
    input  logic [63:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] hilo;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            hilo <= ZERO_DWORD;
        end else if (we) begin
            hilo <= wdata;
        end
    end

    assign hi = hilo[63:32];
    assign lo = hilo[31:0];

endmodule

// File: rtl/wb_stage.sv
// MiniMIPS32 write-back stage: selects GPR write data (ALU result or extracted load),
// holds HI/LO and counts retiring writes.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic [ALUOP_W-1:0] wb_aluop_i,
    input  logic [4:0]         wb_wa_i,
    input  logic               wb_wreg_i,
    input  logic               wb_whilo_i,
    input  logic               wb_mreg_i,
    input  logic [31:0]        wb_dreg_i,
    input  logic [63:0]        wb_dhilo_i,
    input  logic [3:0]         wb_dre_i,
    input  logic [31:0]        dm_i,
    output logic [4:0]         wb_wa_o,
    output logic               wb_wreg_o,
    output logic [31:0]        wb_wd_o,
    output logic               wb_whilo_o,
    output logic [63:0]        wb_dhilo_o,
    output logic [31:0]        hi_o,
    output logic [31:0]        lo_o,
    output logic [CNT_W-1:0]   retire_cnt_o
);

    logic [31:0]      load_data;
    logic             sign_ext;
    logic [CNT_W-1:0] retire_cnt;

    // Regfile and HI/LO forwarding paths are pure pass-through.
    assign wb_wa_o    = wb_wa_i;
    assign wb_wreg_o  = wb_wreg_i;
    assign wb_whilo_o = wb_whilo_i;
    assign wb_dhilo_o = wb_dhilo_i;

    assign sign_ext = (wb_aluop_i == ALUOP_LB) || (wb_aluop_i == ALUOP_LH);

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        load_data = ZERO_WORD;
        case (wb_aluop_i)
            ALUOP_LB, ALUOP_LBU: begin
                case (wb_dre_i)
                    4'b0001: load_data = ext_byte(dm_i[7:0],   sign_ext);
                    4'b0010: load_data = ext_byte(dm_i[15:8],  sign_ext);
                    4'b0100: load_data = ext_byte(dm_i[23:16], sign_ext);
                    4'b1000: load_data = ext_byte(dm_i[31:24], sign_ext);
                    default: load_data = ZERO_WORD;
                endcase
            end
            ALUOP_LH, ALUOP_LHU: begin
                case (wb_dre_i)
                    4'b0011: load_data = ext_half(dm_i[15:0],  sign_ext);
                    4'b1100: load_data = ext_half(dm_i[31:16], sign_ext);
                    default: load_data = ZERO_WORD;
                endcase
            end
            ALUOP_LW: begin
                if (wb_dre_i == 4'b1111) begin
                    load_data = dm_i;
                end
            end
            default: load_data = ZERO_WORD;
        endcase
    end

    assign wb_wd_o = wb_mreg_i ? load_data : wb_dreg_i;

    hilo_reg u_hilo_reg (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .we          (wb_whilo_i),
        .wdata       (wb_dhilo_i),
        .hi          (hi_o),
        .lo          (lo_o)
    );

    // NOTE: only real architectural state is reset here; pure datapath needs none.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            retire_cnt <= '0;
        end else if (wb_wreg_i || wb_whilo_i) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt_o = retire_cnt;

endmodule
